// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and the universal shift register it drives.
// Holds the register mode encoding, the sequencer state encoding and the default width.
package shift_sequencer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/universal_shift_reg.sv
// 16-bit universal shift register: hold, shift right, shift left or parallel load.
// Right shift inserts din at the MSB; left shift inserts din at the LSB.
module universal_shift_reg
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;

  always_comb begin
    dout_d = dout_q;
    unique case (mode)
      MODE_HOLD:  dout_d = dout_q;
      MODE_RIGHT: dout_d = {din, dout_q[WIDTH-1:1]};
      MODE_LEFT:  dout_d = {dout_q[WIDTH-2:0], din};
      MODE_LOAD:  dout_d = data;
      default:    dout_d = dout_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/shift_sequencer.sv
// Control stage for the universal shift register: accepts a frame, issues one load,
// N shifts and a done pulse, and exports the exiting bit on every shift cycle.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_fill,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_din,
  input  logic [WIDTH-1:0] sr_dout,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic             fill_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] count_sat;
  logic             accept;
  logic [IDX_W-1:0] ser_idx;

  assign count_sat = (32'(in_count) > WIDTH) ? CNT_W'(WIDTH) : in_count;
  assign accept    = in_valid && (state_q == StIdle);

  // State register with the latched frame and the remaining-shift counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_data;
        dir_q  <= in_dir;
        fill_q <= in_fill;
        rem_q  <= count_sat;
      end else if (state_q == StShift) begin
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad;
      StLoad:  state_d = (rem_q != '0) ? StShift : StDone;
      StShift: if (rem_q == CNT_W'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    sr_mode   = MODE_HOLD;
    sr_din    = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = !rst;
        busy     = 1'b0;
      end
      StLoad:  sr_mode = MODE_LOAD;
      StShift: begin
        sr_mode   = dir_q ? MODE_LEFT : MODE_RIGHT;
        sr_din    = fill_q;
        ser_valid = 1'b1;
      end
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign sr_data = data_q;

  // Exiting bit is the end opposite the fill: LSB for right shifts, MSB for left.
  assign ser_idx = dir_q ? IDX_W'(WIDTH - 1) : '0;
  assign ser_out = ser_valid ? sr_dout[ser_idx] : 1'b0;

endmodule
